// File: rtl/dmem_wbuf_sram.sv
// dmem_wbuf_sram: D-memory responder with a posted write buffer, byte-wise read forwarding, 1-cycle reads.
// Define DMEM_COALESCE_EN to merge writes to an already-buffered word into its existing entry.
`default_nettype none

module dmem_wbuf_sram #(
  parameter int AWIDTH   = 12,
  parameter int SIZE     = 4096,
  parameter int WB_DEPTH = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             CSN,
  input  logic                             WEN,
  input  logic [3:0]                       BE,
  input  logic [AWIDTH-1:0]                ADDR,
  input  logic [31:0]                      DI,
  output logic [31:0]                      DOUT,
  output logic [$clog2(WB_DEPTH+1)-1:0]    WB_COUNT,
  output logic                             WB_EMPTY
);

  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int IW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int MW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [31:0]       mem     [SIZE];

  // Shift-register buffer: index 0 is the head (oldest), higher indices are younger.
  logic [AWIDTH-1:0] wb_addr [WB_DEPTH];
  logic [3:0]        wb_be   [WB_DEPTH];
  logic [31:0]       wb_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] wb_vld;
  logic [CW-1:0]     count;

  logic [AWIDTH-1:0] nx_addr [WB_DEPTH];
  logic [3:0]        nx_be   [WB_DEPTH];
  logic [31:0]       nx_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] nx_vld;
  logic [CW-1:0]     nx_count;
  logic [CW-1:0]     base_count;
  logic [CW-1:0]     merge_pos;

  logic              do_read;
  logic              do_write;
  logic              full;
  logic              hit;
  logic [IW-1:0]     hit_idx;
  logic              drain;
  logic              head_in_range;
  logic              rd_in_range;
  logic [31:0]       rd_word;

  always_comb begin
    do_read  = !CSN && WEN;
    do_write = !CSN && !WEN && (BE != 4'b0000);
    full     = (count == CW'(WB_DEPTH));
    hit      = 1'b0;
    hit_idx  = '0;
`ifdef DMEM_COALESCE_EN
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (wb_vld[i] && (wb_addr[i] == ADDR)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
`endif
    // Idle cycles drain; a write drains only to make room, and a coalescing write never needs room.
    drain = wb_vld[0] && (do_write ? (full && !hit) : !do_read);
    head_in_range = int'(wb_addr[0]) < SIZE;
    rd_in_range   = int'(ADDR) < SIZE;
  end

  always_comb begin
    for (int i = 0; i < WB_DEPTH; i++) begin
      nx_addr[i] = wb_addr[i];
      nx_be[i]   = wb_be[i];
      nx_data[i] = wb_data[i];
    end
    nx_vld     = wb_vld;
    base_count = count;
    if (drain) begin
      for (int i = 0; i < WB_DEPTH - 1; i++) begin
        nx_addr[i] = wb_addr[i+1];
        nx_be[i]   = wb_be[i+1];
        nx_data[i] = wb_data[i+1];
      end
      nx_vld     = wb_vld >> 1;
      base_count = count - CW'(1);
    end
    nx_count  = base_count;
    merge_pos = CW'(hit_idx) - CW'(drain);
    if (do_write) begin
      if (hit) begin
        for (int i = 0; i < WB_DEPTH; i++) begin
          if (CW'(i) == merge_pos) begin
            for (int b = 0; b < 4; b++) begin
              if (BE[b]) nx_data[i][8*b +: 8] = DI[8*b +: 8];
            end
            nx_be[i] = nx_be[i] | BE;
          end
        end
      end else begin
        for (int i = 0; i < WB_DEPTH; i++) begin
          if (CW'(i) == base_count) begin
            nx_addr[i] = ADDR;
            nx_be[i]   = BE;
            nx_data[i] = DI;
            nx_vld[i]  = 1'b1;
          end
        end
        nx_count = base_count + CW'(1);
      end
    end
  end

  // Forwarding walks oldest to youngest so the youngest matching byte wins.
  always_comb begin
    rd_word = rd_in_range ? mem[ADDR[MW-1:0]] : 32'h0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (wb_vld[i] && (wb_addr[i] == ADDR)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_be[i][b]) rd_word[8*b +: 8] = wb_data[i][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (drain && head_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be[0][b]) mem[wb_addr[0][MW-1:0]][8*b +: 8] <= wb_data[0][8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < WB_DEPTH; i++) begin
      wb_addr[i] <= nx_addr[i];
      wb_be[i]   <= nx_be[i];
      wb_data[i] <= nx_data[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT   <= 32'h0;
      count  <= '0;
      wb_vld <= '0;
    end else begin
      if (do_read) DOUT <= rd_word;
      count  <= nx_count;
      wb_vld <= nx_vld;
    end
  end

  assign WB_COUNT = count;
  assign WB_EMPTY = (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_dmem_wbuf_sram.sv
// Self-checking bench for dmem_wbuf_sram: scoreboard of expected read data, one task per scenario.
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_wbuf_sram;

  localparam int AWIDTH   = 12;
  localparam int SIZE     = 4000;
  localparam int WB_DEPTH = 4;
`ifdef DMEM_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              csn;
  logic              wen;
  logic [3:0]        be;
  logic [AWIDTH-1:0] addr;
  logic [31:0]       di;
  logic [31:0]       dout;
  logic [2:0]        wb_count;
  logic              wb_empty;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_wbuf_sram #(
    .AWIDTH  (AWIDTH),
    .SIZE    (SIZE),
    .WB_DEPTH(WB_DEPTH)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .CSN     (csn),
    .WEN     (wen),
    .BE      (be),
    .ADDR    (addr),
    .DI      (di),
    .DOUT    (dout),
    .WB_COUNT(wb_count),
    .WB_EMPTY(wb_empty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_idle();
    csn = 1'b1; wen = 1'b1; be = 4'h0; addr = '0; di = 32'h0;
  endtask

  task automatic drv_write(input logic [AWIDTH-1:0] a, input logic [3:0] b, input logic [31:0] d);
    csn = 1'b0; wen = 1'b0; be = b; addr = a; di = d;
  endtask

  task automatic drv_read(input logic [AWIDTH-1:0] a, input logic [31:0] exp);
    csn = 1'b0; wen = 1'b1; be = 4'h0; addr = a; di = 32'h0;
    exp_q.push_back(exp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv_idle();
    step(); step();
    total++; if (dout !== 32'h0) $display("FAIL reset_dout: got %h expected %h", dout, 32'h0); else passed++;
    total++; if (wb_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", wb_count); else passed++;
    total++; if (wb_empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", wb_empty); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_forward();
    logic [31:0] e;
    drv_write(12'd5, 4'hF, 32'h0A0B0C0D); step();
    drv_read(12'd5, 32'h0A0B0C0D); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL fwd_read: got %h expected %h", dout, e); else passed++;
    total++; if (wb_count !== 3'd1) $display("FAIL fwd_still_buffered: got %0d expected 1", wb_count); else passed++;
    drv_idle(); step();
    total++; if (wb_count !== 3'd0) $display("FAIL fwd_drained: got %0d expected 0", wb_count); else passed++;
  endtask

  task automatic test_partial();
    logic [31:0] e;
    drv_write(12'd7, 4'hF, 32'h11223344); step();
    drv_idle(); step();
    drv_write(12'd7, 4'b0010, 32'h0000AA00); step();
    drv_read(12'd7, 32'h1122AA44); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL partial_fwd: got %h expected %h", dout, e); else passed++;
    drv_idle(); step();
    drv_read(12'd7, 32'h1122AA44); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL partial_array: got %h expected %h", dout, e); else passed++;
    drv_idle(); step();
  endtask

  task automatic test_full();
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      drv_write(AWIDTH'(i), 4'hF, 32'hC0DE0000 + 32'(i)); step();
      total++;
      if (wb_count !== 3'((i < 4) ? i + 1 : 4))
        $display("FAIL full_count[%0d]: got %0d expected %0d", i, wb_count, (i < 4) ? i + 1 : 4);
      else passed++;
    end
    drv_idle();
    repeat (4) step();
    total++; if (wb_empty !== 1'b1) $display("FAIL full_empty: got %b expected 1", wb_empty); else passed++;
    for (int i = 0; i < 6; i++) begin
      drv_read(AWIDTH'(i), 32'hC0DE0000 + 32'(i)); step();
      e = exp_q.pop_front();
      total++; if (dout !== e) $display("FAIL full_array[%0d]: got %h expected %h", i, dout, e); else passed++;
    end
    drv_idle(); step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] last;
    last = 32'h0;
    drv_write(12'd30, 4'hF, 32'hAAAA0030); step();
    drv_write(12'd31, 4'hF, 32'hBBBB0031); step();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) drv_read(12'd30, 32'hAAAA0030);
      else            drv_read(12'd31, 32'hBBBB0031);
      step();
      e = exp_q.pop_front();
      last = e;
      total++; if (dout !== e) $display("FAIL b2b_read[%0d]: got %h expected %h", i, dout, e); else passed++;
      total++; if (wb_count !== 3'd2) $display("FAIL b2b_count[%0d]: got %0d expected 2", i, wb_count); else passed++;
    end
    drv_idle(); step();
    total++; if (wb_count !== 3'd1) $display("FAIL b2b_idle1: got %0d expected 1", wb_count); else passed++;
    total++; if (dout !== last) $display("FAIL b2b_hold: got %h expected %h", dout, last); else passed++;
    step();
    total++; if (wb_count !== 3'd0) $display("FAIL b2b_idle2: got %0d expected 0", wb_count); else passed++;
  endtask

  task automatic test_coalesce();
    logic [31:0] e;
    drv_write(12'd9, 4'hF, 32'h0); step();
    drv_idle(); step();
    drv_write(12'd9, 4'b0001, 32'h000000FF); step();
    drv_write(12'd9, 4'b1000, 32'h12000000); step();
    total++;
    if (wb_count !== (COALESCE ? 3'd1 : 3'd2))
      $display("FAIL coalesce_count: got %0d expected %0d", wb_count, COALESCE ? 1 : 2);
    else passed++;
    drv_read(12'd9, 32'h120000FF); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL coalesce_read: got %h expected %h", dout, e); else passed++;
    drv_idle(); step(); step();
    total++; if (wb_empty !== 1'b1) $display("FAIL coalesce_empty: got %b expected 1", wb_empty); else passed++;
    drv_read(12'd9, 32'h120000FF); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL coalesce_array: got %h expected %h", dout, e); else passed++;
    drv_idle(); step();
  endtask

  task automatic test_out_of_range();
    logic [31:0] e;
    drv_write(12'd4050, 4'hF, 32'hDEADBEEF); step();
    drv_read(12'd4050, 32'hDEADBEEF); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL oor_fwd: got %h expected %h", dout, e); else passed++;
    drv_idle(); step();
    drv_read(12'd4050, 32'h0); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL oor_dropped: got %h expected %h", dout, e); else passed++;
    drv_write(12'd4050, 4'b0100, 32'h00550000); step();
    drv_read(12'd4050, 32'h00550000); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL oor_partial: got %h expected %h", dout, e); else passed++;
    drv_idle(); step();
  endtask

  task automatic test_reset_midrun();
    logic [31:0] e;
    for (int k = 0; k < 3; k++) begin
      drv_write(AWIDTH'(20 + k), 4'hF, 32'h50000020 + 32'(k)); step();
    end
    drv_idle(); repeat (3) step();
    drv_read(12'd20, 32'h50000020); step();
    e = exp_q.pop_front();
    total++; if (dout !== e) $display("FAIL mid_pre_read: got %h expected %h", dout, e); else passed++;
    for (int k = 0; k < 3; k++) begin
      drv_write(AWIDTH'(20 + k), 4'hF, 32'h60000020 + 32'(k)); step();
    end
    total++; if (wb_count !== 3'd3) $display("FAIL mid_buffered: got %0d expected 3", wb_count); else passed++;
    // Read in flight when reset arrives: must return 0.
    csn = 1'b0; wen = 1'b1; be = 4'h0; addr = 12'd21;
    #2 rst = 1'b1;
    step();
    total++; if (dout !== 32'h0) $display("FAIL mid_dout: got %h expected %h", dout, 32'h0); else passed++;
    total++; if (wb_count !== 3'd0) $display("FAIL mid_count: got %0d expected 0", wb_count); else passed++;
    total++; if (wb_empty !== 1'b1) $display("FAIL mid_empty: got %b expected 1", wb_empty); else passed++;
    drv_idle();
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      drv_read(AWIDTH'(20 + k), 32'h50000020 + 32'(k)); step();
      e = exp_q.pop_front();
      total++; if (dout !== e) $display("FAIL mid_post_read[%0d]: got %h expected %h", k, dout, e); else passed++;
    end
    drv_idle(); step();
  endtask

  initial begin
    rst = 1'b1;
    drv_idle();
    test_reset();
    test_write_forward();
    test_partial();
    test_full();
    test_back_to_back();
    test_coalesce();
    test_out_of_range();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
